stack_access_ctrl: RTL
======================

STACK_ACCESS_CTRL -- requirements
Module: stack_access_ctrl

Interface
REQ-001 Parameter STACK_TOP, default 8'hFF: first stack slot address and empty-pointer value.
REQ-002 Parameter STACK_LIMIT, default 8'hAF: full-pointer value, giving 80 usable slots (FF..B0).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 push_req  input  1  push request, sampled only in IDLE.
REQ-006 push_data  input  8  push value, captured with push_req.
REQ-007 pop_req  input  1  pop request, sampled only in IDLE.
REQ-008 pop_data  output  8  popped value, registered.
REQ-009 pop_valid  output  1  one-cycle strobe qualifying pop_data.
REQ-010 busy  output  1  high in every non-IDLE state; requests are ignored while high.
REQ-011 full / empty  output  1 each  sp==STACK_LIMIT / sp==STACK_TOP.
REQ-012 overflow_err / underflow_err  output  1 each  one-cycle strobes on a rejected push / pop.
REQ-013 mem_addr  output  8  data-memory address.
REQ-014 mem_wdata  output  8  data-memory write data.
REQ-015 mem_we / mem_re  output  1 each  write / read enables.
REQ-016 mem_rdata  input  8  read data, valid exactly one cycle after mem_re.
REQ-017 sp_out  output  8  current stack pointer.

Function
REQ-018 8-bit sp SHALL point at the next free slot: push writes at sp then decrements; pop increments then reads at the new sp.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, CAPTURE.
REQ-020 IDLE with push_req and not full -> WRITE, latching push_data; WRITE drives mem_we=1, mem_addr=sp, mem_wdata=latched data, decrements sp at cycle end, then returns to IDLE.
REQ-021 IDLE with pop_req, no push_req and not empty -> READ, incrementing sp on that edge; READ drives mem_re=1, mem_addr=sp -> CAPTURE.
REQ-022 CAPTURE SHALL register mem_rdata into pop_data and set pop_valid for the following cycle (in IDLE), then -> IDLE.
REQ-023 Latency: push request at cycle N writes memory in N+1; pop request at N gives pop_valid at N+3.
REQ-024 push_req and pop_req both high in IDLE: push SHALL be serviced and pop dropped without error.
REQ-025 push_req when full: no state change or memory write, overflow_err=1 for the next cycle.
REQ-026 pop_req when empty: no state change or memory read, underflow_err=1 for the next cycle.
REQ-027 sp SHALL never leave [STACK_LIMIT, STACK_TOP]; no wrap-around.
REQ-028 mem_we and mem_re SHALL never be high together and SHALL be 0 outside WRITE/READ.

Reset
REQ-029 On rst_n low, immediately: state=IDLE, sp=STACK_TOP, pop_data=8'h00, pop_valid=0, both error strobes=0, mem_we=0, mem_re=0.
REQ-030 Reset mid-operation SHALL abort the operation; an aborted write does not count, and no pop_valid is emitted.

Configuration
REQ-031 Macro STACK_HWM_EN defined: output hwm[7:0] SHALL track the lowest sp reached since reset; reset value STACK_TOP, updated when sp decrements below it.
REQ-032 Macro STACK_HWM_EN undefined: hwm SHALL be tied to STACK_TOP and no tracking register exists.

Structure
REQ-033 Package stack_pkg SHALL hold the FSM state enum typedef, the STACK_TOP/STACK_LIMIT defaults and the stack-depth constant (80).
REQ-034 Single module, no sub-modules; the memory is external.

Verification
REQ-035 Reset, then push 8'hA5 -> mem_we at addr FF with data A5 in cycle N+1; sp_out=FE; empty=0.
REQ-036 Push 11,22,33, then pop x3 -> pop_data 33,22,11 with pop_valid each at N+3; empty=1 at the end.
REQ-037 80 pushes -> full=1, sp_out=AF; 81st push -> overflow_err pulse, no mem_we, sp unchanged.
REQ-038 Pop after reset -> underflow_err pulse, no mem_re, sp_out=FF.
REQ-039 push_req+pop_req together in IDLE -> push only, no pop_valid; requests while busy=1 are ignored.
REQ-040 rst_n low during READ -> sp_out=FF, no pop_valid; with STACK_HWM_EN, 5 pushes then 5 pops -> hwm=FA.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack access controller.
package stack_pkg;

  localparam logic [7:0] DEF_STACK_TOP   = 8'hFF;
  localparam logic [7:0] DEF_STACK_LIMIT = 8'hAF;
  localparam int         STACK_DEPTH     = 80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/stack_access_ctrl.sv
// Stack access controller: turns push/pop requests into accesses on an
// external synchronous data memory. The stack grows downward from STACK_TOP
// to STACK_LIMIT, and sp always points at the next free slot.
// Optional feature: define STACK_HWM_EN to track the lowest sp since reset
// on the hwm output. Without it, hwm is a constant STACK_TOP.
module stack_access_ctrl
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_TOP   = DEF_STACK_TOP,
  parameter logic [7:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_req,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] pop_data,
  output logic       pop_valid,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow_err,
  output logic       underflow_err,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic [7:0] sp_out,
  output logic [7:0] hwm
);

  state_t     state;
  state_t     next_state;
  logic [7:0] sp;
  logic [7:0] wdata_q;
  logic       accept_push;
  logic       accept_pop;

  // A push always wins over a simultaneous pop; the pop is silently dropped.
  assign full        = (sp == STACK_LIMIT);
  assign empty       = (sp == STACK_TOP);
  assign accept_push = (state == IDLE) && push_req && !full;
  assign accept_pop  = (state == IDLE) && !push_req && pop_req && !empty;
  assign sp_out      = sp;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: each accepted request runs a fixed sequence back to IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept_push)     next_state = WRITE;
        else if (accept_pop) next_state = READ;
      end
      WRITE:   next_state = IDLE;
      READ:    next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: memory strobes only in WRITE/READ, busy whenever not IDLE.
  always_comb begin
    busy      = (state != IDLE);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = sp;
    mem_wdata = 8'h00;
    unique case (state)
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
      end
      READ:    mem_re = 1'b1;
      default: ;
    endcase
  end

  // Stack pointer: decrements after a write, increments before a read; the
  // bound guards keep it inside [STACK_LIMIT, STACK_TOP] with no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= STACK_TOP;
    end else if (state == WRITE && sp != STACK_LIMIT) begin
      sp <= sp - 8'd1;
    end else if (accept_pop && sp != STACK_TOP) begin
      sp <= sp + 8'd1;
    end
  end

  // Push data is held for the WRITE cycle so the requester may change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           wdata_q <= 8'h00;
    else if (accept_push) wdata_q <= push_data;
  end

  // Registered pop result and single-cycle status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data      <= 8'h00;
      pop_valid     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pop_valid     <= (state == CAPTURE);
      overflow_err  <= (state == IDLE) && push_req && full;
      underflow_err <= (state == IDLE) && !push_req && pop_req && empty;
      if (state == CAPTURE) pop_data <= mem_rdata;
    end
  end

`ifdef STACK_HWM_EN
  logic [7:0] hwm_q;

  // Low-water mark of sp: follows each decrement that goes below the record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= STACK_TOP;
    end else if (state == WRITE && sp != STACK_LIMIT && (sp - 8'd1) < hwm_q) begin
      hwm_q <= sp - 8'd1;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = STACK_TOP;
`endif

endmodule
